multicycle_control_unit: RTL

Multi-cycle controller for the RV32I+M core: a state machine that sequences fetch, decode, execute, memory and write-back with valid/ack handshakes to instruction and data memory. It replaces purely combinational opcode decode. It registers the instruction and emits per-state control strobes to the datapath (PC, register file, ALU, immediate generator). It also supports a variable-latency divide/remainder, I-type ALU variants, `blt` via `slt`, and an illegal-instruction trap.

---
 rtl/multicycle_control_unit.sv | 313 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle controller for the RV32I+M core: sequences fetch, decode, execute,
// memory and write-back with memory handshakes and drives the datapath strobes.
module multicycle_control_unit #(
    parameter int DIV_CYCLES = 8,
    parameter bit ENABLE_M   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic        alu_zero,
    output logic [31:0] ir,
    output logic        pc_write,
    output logic [1:0]  pc_sel,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        alu_a_pc,
    output logic        alu_src,
    output logic [3:0]  alu_control,
    output logic [2:0]  imm_control,
    output logic        illegal
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_SLT = 4'b0011;
    localparam logic [3:0] ALU_DIV = 4'b0100;
    localparam logic [3:0] ALU_REM = 4'b0101;
    localparam logic [3:0] ALU_SLL = 4'b0110;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1000;

    localparam logic [2:0] IMM_R = 3'b000;
    localparam logic [2:0] IMM_I = 3'b001;
    localparam logic [2:0] IMM_S = 3'b010;
    localparam logic [2:0] IMM_B = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;
    localparam logic [2:0] IMM_J = 3'b101;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JAL    = 2'b10;
    localparam logic [1:0] PC_JALR   = 2'b11;

    localparam logic [1:0] WB_ALU   = 2'b00;
    localparam logic [1:0] WB_LOAD  = 2'b01;
    localparam logic [1:0] WB_PC4   = 2'b10;
    localparam logic [1:0] WB_UIMM  = 2'b11;

    // The div counter only needs to hold DIV_CYCLES-1.
    localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        C_NONE,
        C_ALU,
        C_DIV,
        C_LOAD,
        C_STORE,
        C_BRANCH,
        C_LUI,
        C_AUIPC,
        C_JAL,
        C_JALR
    } cls_t;

    state_t           state;
    state_t           next_state;
    logic [31:0]      ir_q;
    logic [CNT_W-1:0] div_cnt;

    cls_t       cls;
    logic [3:0] dec_alu;
    logic [2:0] dec_imm;
    logic       dec_src;
    logic       dec_apc;
    logic [1:0] dec_wb;
    logic       dec_beq;
    logic       branch_taken;

    // Instruction class and datapath controls, decoded from the held instruction.
    always_comb begin
        cls     = C_NONE;
        dec_alu = ALU_ADD;
        dec_imm = IMM_R;
        dec_src = 1'b0;
        dec_apc = 1'b0;
        dec_wb  = WB_ALU;
        dec_beq = 1'b0;
        case (ir_q[6:0])
            OP_R: begin
                cls = C_ALU;
                case ({ir_q[31:25], ir_q[14:12]})
                    10'b0000000_000: dec_alu = ALU_ADD;
                    10'b0100000_000: dec_alu = ALU_SUB;
                    10'b0000000_111: dec_alu = ALU_AND;
                    10'b0000000_010: dec_alu = ALU_SLT;
                    10'b0000000_001: dec_alu = ALU_SLL;
                    10'b0000000_101: dec_alu = ALU_SRL;
                    10'b0100000_101: dec_alu = ALU_SRA;
                    10'b0000001_100: begin
                        dec_alu = ALU_DIV;
                        cls     = ENABLE_M ? C_DIV : C_NONE;
                    end
                    10'b0000001_110: begin
                        dec_alu = ALU_REM;
                        cls     = ENABLE_M ? C_DIV : C_NONE;
                    end
                    default: cls = C_NONE;
                endcase
            end
            OP_IMM: begin
                cls     = C_ALU;
                dec_imm = IMM_I;
                dec_src = 1'b1;
                case (ir_q[14:12])
                    3'b000: dec_alu = ALU_ADD;
                    3'b010: dec_alu = ALU_SLT;
                    3'b111: dec_alu = ALU_AND;
                    3'b001: begin
                        dec_alu = ALU_SLL;
                        if (ir_q[31:25] != 7'b0000000) cls = C_NONE;
                    end
                    3'b101: begin
                        if (ir_q[31:25] == 7'b0000000)      dec_alu = ALU_SRL;
                        else if (ir_q[31:25] == 7'b0100000) dec_alu = ALU_SRA;
                        else                                cls = C_NONE;
                    end
                    default: cls = C_NONE;
                endcase
            end
            OP_LOAD: begin
                cls     = C_LOAD;
                dec_imm = IMM_I;
                dec_src = 1'b1;
                dec_wb  = WB_LOAD;
            end
            OP_STORE: begin
                cls     = C_STORE;
                dec_imm = IMM_S;
                dec_src = 1'b1;
            end
            OP_BRANCH: begin
                dec_imm = IMM_B;
                case (ir_q[14:12])
                    3'b000: begin
                        cls     = C_BRANCH;
                        dec_alu = ALU_SUB;
                        dec_beq = 1'b1;
                    end
                    3'b100: begin
                        cls     = C_BRANCH;
                        dec_alu = ALU_SLT;
                    end
                    default: cls = C_NONE;
                endcase
            end
            OP_LUI: begin
                cls     = C_LUI;
                dec_imm = IMM_U;
                dec_wb  = WB_UIMM;
            end
            OP_AUIPC: begin
                cls     = C_AUIPC;
                dec_imm = IMM_U;
                dec_apc = 1'b1;
            end
            OP_JAL: begin
                cls     = C_JAL;
                dec_imm = IMM_J;
                dec_wb  = WB_PC4;
            end
            OP_JALR: begin
                cls     = C_JALR;
                dec_imm = IMM_I;
                dec_src = 1'b1;
                dec_wb  = WB_PC4;
            end
            default: cls = C_NONE;
        endcase
    end

    // beq is taken on a zero difference, blt on a nonzero slt result.
    assign branch_taken = dec_beq ? alu_zero : !alu_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            ir_q    <= '0;
            div_cnt <= '0;
        end else begin
            state <= next_state;
            if (state == S_FETCH && imem_ack) begin
                ir_q <= imem_rdata;
            end
            if (state == S_DECODE) begin
                div_cnt <= DIV_INIT;
            end else if (state == S_EXEC && cls == C_DIV && div_cnt != '0) begin
                div_cnt <= div_cnt - CNT_W'(1);
            end
        end
    end

    always_comb begin
        next_state  = state;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        pc_write    = 1'b0;
        pc_sel      = PC_PLUS4;
        reg_write   = 1'b0;
        wb_sel      = WB_ALU;
        alu_a_pc    = 1'b0;
        alu_src     = 1'b0;
        alu_control = ALU_ADD;
        imm_control = IMM_R;
        illegal     = 1'b0;
        ir          = ir_q;

        if (state != S_TRAP) begin
            wb_sel      = dec_wb;
            alu_a_pc    = dec_apc;
            alu_src     = dec_src;
            alu_control = dec_alu;
            imm_control = dec_imm;
        end

        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) next_state = S_DECODE;
            end
            S_DECODE: begin
                next_state = (cls == C_NONE) ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                case (cls)
                    C_BRANCH: begin
                        pc_write   = 1'b1;
                        pc_sel     = branch_taken ? PC_BRANCH : PC_PLUS4;
                        next_state = S_FETCH;
                    end
                    C_LOAD, C_STORE: next_state = S_MEM;
                    C_DIV: if (div_cnt == '0) next_state = S_WB;
                    default: next_state = S_WB;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls == C_STORE);
                if (dmem_ack) begin
                    if (cls == C_STORE) begin
                        pc_write   = 1'b1;
                        next_state = S_FETCH;
                    end else begin
                        next_state = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                next_state = S_FETCH;
                if (cls == C_JAL)       pc_sel = PC_JAL;
                else if (cls == C_JALR) pc_sel = PC_JALR;
            end
            S_TRAP: illegal = 1'b1;
            default: next_state = S_FETCH;
        endcase

        // Reset silences every output, including requests in flight.
        if (rst) begin
            imem_req    = 1'b0;
            dmem_req    = 1'b0;
            dmem_we     = 1'b0;
            pc_write    = 1'b0;
            pc_sel      = PC_PLUS4;
            reg_write   = 1'b0;
            wb_sel      = WB_ALU;
            alu_a_pc    = 1'b0;
            alu_src     = 1'b0;
            alu_control = ALU_ADD;
            imm_control = IMM_R;
            illegal     = 1'b0;
            ir          = '0;
        end
    end

endmodule
